// File: rtl/perm_pkg.sv
// Shared geometry and FSM state encoding for the permuted-state unloader.
package perm_pkg;
    localparam int DIM   = 5;
    localparam int LANES = DIM * DIM;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } perm_state_e;

    // Lane index is DIM*y + x (x fastest).
    function automatic logic [2:0] lane_x(input int idx);
        return 3'(idx % DIM);
    endfunction

    function automatic logic [2:0] lane_y(input int idx);
        return 3'(idx / DIM);
    endfunction
endpackage

// File: rtl/perm_unload_if.sv
// Unloader bundle: start/busy/done control, registered state-memory read port, lane stream.
// master = unloader side, slave = environment (memory, controller, downstream sink).
interface perm_unload_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  mrx;
    logic [2:0]  mry;
    logic [63:0] mrd;
    logic        pushout;
    logic        stopout;
    logic        firstout;
    logic [63:0] dout;

    modport master (
        input  start, mrd, stopout,
        output busy, done, mrx, mry, pushout, firstout, dout
    );

    modport slave (
        output start, mrd, stopout,
        input  busy, done, mrx, mry, pushout, firstout, dout
    );
endinterface

// File: rtl/perm_unload_lane_fifo.sv
// Shift-register FIFO, head always in entry 0 so the output is a plain register; push visible next cycle.
// Backpressure: caller must not push into a full FIFO unless it pops in the same cycle.
module lane_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 65,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic [WIDTH-1:0] ent_q [DEPTH];
    logic [WIDTH-1:0] ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop;

    assign pop = pop_i && vld_q[0];

    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        wr_idx = cnt_q;
        // Empty slots are kept at zero so the head never shows stale data or tags.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = vld_q[i+1] ? ent_q[i+1] : '0;
                vld_d[i] = vld_q[i+1];
            end
            ent_d[DEPTH-1] = '0;
            vld_d[DEPTH-1] = 1'b0;
            cnt_d          = cnt_q - 1'b1;
            wr_idx         = cnt_q - 1'b1;
        end
        if (push_i && (pop || !vld_q[DEPTH-1])) begin
            ent_d[wr_idx] = dat_i;
            vld_d[wr_idx] = 1'b1;
            cnt_d         = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign vld_o = vld_q[0];
    assign dat_o = ent_q[0];
    assign cnt_o = cnt_q;
endmodule

// File: rtl/perm_unload.sv
// Streams the 25 lanes of a permuted state from state memory in x-fastest order; start -> lane 0 in 3 cycles.
// Reads are credit-limited by FIFO occupancy + in-flight read, so stopout stalls the stream without overflow.
module perm_unload #(
    parameter int LANES      = perm_pkg::LANES,
    parameter int FIFO_DEPTH = 3
) (
    input logic           clk,
    input logic           rst,
    perm_unload_if.master bus
);
    import perm_pkg::*;

    localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [4:0] LAST_LANE = 5'(LANES - 1);
    localparam logic [4:0] ALL_LANES = 5'(LANES);

    perm_state_e      state_q, state_d;
    logic [4:0]       rd_cnt_q, rd_cnt_d;
    logic [4:0]       xf_cnt_q, xf_cnt_d;
    logic [2:0]       x_q, x_d;
    logic [2:0]       y_q, y_d;
    logic             rd_vld_q, rd_first_q;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             issue;
    logic             xfer;
    logic             fifo_vld;
    logic [64:0]      fifo_dat;
    logic [CNT_W-1:0] fifo_cnt;

    // Credit ignores a same-cycle pop so stopout has no path into the address counters.
    assign issue = (state_q == S_RUN) && (rd_cnt_q != ALL_LANES)
                && ((int'(fifo_cnt) + int'(rd_vld_q)) < FIFO_DEPTH);
    assign xfer  = fifo_vld && !bus.stopout;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        xf_cnt_d = xf_cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    state_d  = S_RUN;
                    rd_cnt_d = '0;
                    xf_cnt_d = '0;
                    x_d      = '0;
                    y_d      = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (x_q == 3'd4) begin
                        x_d = '0;
                        y_d = (y_q == 3'd4) ? 3'd0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (rd_cnt_q == LAST_LANE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: ;
        endcase

        if (xfer && (state_q != S_IDLE)) begin
            if (xf_cnt_q != ALL_LANES) begin
                xf_cnt_d = xf_cnt_q + 1'b1;
            end
            if (xf_cnt_q == LAST_LANE) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign busy_d = (state_d != S_IDLE) || done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            xf_cnt_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            xf_cnt_q   <= xf_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_vld_q   <= issue;
            rd_first_q <= issue && (rd_cnt_q == '0);
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    lane_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_vld_q),
        .dat_i  ({rd_first_q, bus.mrd}),
        .pop_i  (xfer),
        .vld_o  (fifo_vld),
        .dat_o  (fifo_dat),
        .cnt_o  (fifo_cnt)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mrx      = x_q;
    assign bus.mry      = y_q;
    assign bus.pushout  = fifo_vld;
    assign bus.firstout = fifo_dat[64];
    assign bus.dout     = fifo_dat[63:0];
endmodule

// File: tb/tb_perm_unload.sv
// Bench for perm_unload: scenario table (stall patterns, mid-stream start/reset) plus back-to-back run,
// every lane scored against an index-ordered reference queue of the expected stream.
module tb_perm_unload;
    localparam int          NL   = 25;
    localparam logic [63:0] BASE = 64'h0101_0101_0000_0000;

    // mode: 0 stopout low, 1 toggle, 2 random pct; act: 0 none, 1 stall at lane 7,
    // 2 start at lane 12, 3 reset at lane 12. exp_done < 0 means latency not fixed.
    typedef struct {
        int mode;
        int pct;
        int act;
        int exp_first;
        int exp_done;
    } vec_t;

    typedef struct {
        logic [63:0] val;
        logic        first;
    } lane_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    perm_unload_if bus();

    perm_unload #(.LANES(25), .FIFO_DEPTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    xfers = 0;
    int    dones = 0;
    lane_t exp_q[$];
    logic  exp_done_now = 1'b0;
    logic  prev_stall = 1'b0;
    logic  mon_en = 1'b0;

    task automatic chk1(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", nm, got, want);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic chki(input string nm, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    // State memory: lane(x,y) = BASE + 5*y + x, registered read.
    logic [2:0] ax, ay;
    always @(posedge clk) begin
        ax = bus.mrx;
        ay = bus.mry;
        #1 bus.mrd = BASE + 64'(5 * int'(ay) + int'(ax));
    end

    // Stream monitor: head must match the oldest outstanding lane; done follows the 25th transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done_now = 1'b0;
            prev_stall   = 1'b0;
        end else if (mon_en) begin
            chk1("done_pulse", bus.done, exp_done_now);
            if (bus.done) begin
                chk1("busy_at_done", bus.busy, 1'b1);
                dones++;
            end
            exp_done_now = 1'b0;
            chk1("addr_range", (bus.mrx < 3'd5) && (bus.mry < 3'd5), 1'b1);
            if (prev_stall) chk1("hold_pushout", bus.pushout, 1'b1);
            if (bus.pushout) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_lane: got dout %h, required no lane", bus.dout);
                end else begin
                    chk64($sformatf("lane%0d_dout", NL - exp_q.size()), bus.dout, exp_q[0].val);
                    chk1($sformatf("lane%0d_first", NL - exp_q.size()), bus.firstout, exp_q[0].first);
                    if (!bus.stopout) begin
                        void'(exp_q.pop_front());
                        xfers++;
                        if (exp_q.size() == 0) exp_done_now = 1'b1;
                    end
                end
            end
            prev_stall = bus.pushout && bus.stopout;
        end
    end

    task automatic run_stream(input vec_t v, output int first_lat, output int done_lat);
        int stall_left;
        bit acted;
        first_lat  = -1;
        done_lat   = -1;
        stall_left = 0;
        acted      = 1'b0;
        for (int i = 0; i < NL; i++) exp_q.push_back('{val: BASE + 64'(i), first: (i == 0)});
        xfers = 0;
        dones = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            if (bus.done) begin
                done_lat = k;
                break;
            end
            if (k == 1) chk1("busy_after_start", bus.busy, 1'b1);
            if (bus.pushout && first_lat < 0) first_lat = k;
            case (v.mode)
                1:       bus.stopout = k[0];
                2:       bus.stopout = (int'($urandom_range(99)) < v.pct);
                default: bus.stopout = 1'b0;
            endcase
            if (!acted && v.act == 1 && bus.pushout && bus.dout == BASE + 64'd7) begin
                acted      = 1'b1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                bus.stopout = 1'b1;
                stall_left--;
                if (stall_left == 0) begin
                    chki("stall_mrx", int'(bus.mrx), 0);
                    chki("stall_mry", int'(bus.mry), 2);
                end
            end
            if (!acted && v.act == 2 && bus.pushout && bus.dout == BASE + 64'd12) begin
                acted     = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (!acted && v.act == 3 && bus.pushout && bus.dout == BASE + 64'd12) begin
                acted       = 1'b1;
                bus.stopout = 1'b0;
                rst         = 1'b1;
                #1;
                chk1("rst_pushout", bus.pushout, 1'b0);
                chk1("rst_busy", bus.busy, 1'b0);
                chk64("rst_dout", bus.dout, 64'd0);
                done_lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start   = 1'b0;
        bus.stopout = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   fl, dl;
        tbl[0] = '{0,  0, 0, 3, 28};
        tbl[1] = '{1,  0, 0, 3, -1};
        tbl[2] = '{0,  0, 1, 3, 38};
        tbl[3] = '{0,  0, 2, 3, 28};
        tbl[4] = '{2, 30, 0, 3, -1};
        tbl[5] = '{2, 75, 0, 3, -1};
        tbl[6] = '{0,  0, 3, 3, -1};

        bus.start   = 1'b0;
        bus.stopout = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy0", bus.busy, 1'b0);
        chk1("rst_done0", bus.done, 1'b0);
        chk1("rst_pushout0", bus.pushout, 1'b0);
        chk1("rst_firstout0", bus.firstout, 1'b0);
        chk64("rst_dout0", bus.dout, 64'd0);
        chki("rst_mrx0", int'(bus.mrx), 0);
        chki("rst_mry0", int'(bus.mry), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            run_stream(tbl[t], fl, dl);
            @(posedge clk); #1;
            chki($sformatf("t%0d_first_lat", t), fl, tbl[t].exp_first);
            if (tbl[t].exp_done >= 0) chki($sformatf("t%0d_done_lat", t), dl, tbl[t].exp_done);
            else                      chk1($sformatf("t%0d_done_seen", t), dl > 0, 1'b1);
            chki($sformatf("t%0d_lanes", t), xfers, NL);
            chki($sformatf("t%0d_dones", t), dones, 1);
            chk1($sformatf("t%0d_busy_idle", t), bus.busy, 1'b0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset mid-stream, then a clean restart from lane 0.
        run_stream(tbl[6], fl, dl);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk1("post_rst_pushout", bus.pushout, 1'b0);
            chk1("post_rst_busy", bus.busy, 1'b0);
        end
        run_stream(tbl[0], fl, dl);
        chki("rst_restart_first_lat", fl, 3);
        chki("rst_restart_done_lat", dl, 28);

        // start in the done cycle is ignored; held into the next cycle it is accepted.
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk1("start_in_done_ignored", bus.busy, 1'b0);
        chki("prev_lanes", xfers, NL);
        chki("prev_dones", dones, 1);
        run_stream(tbl[0], fl, dl);
        @(posedge clk); #1;
        chki("b2b_first_lat", fl, 3);
        chki("b2b_done_lat", dl, 28);
        chki("b2b_lanes", xfers, NL);
        chki("b2b_dones", dones, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/perm_unload.md
PERM_UNLOAD -- requirements
Module: perm_unload

Interface
REQ-001 Parameters: LANES, 25, lanes per state; FIFO_DEPTH, 3, output buffer entries.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; permuted 5x5x64 state is complete in state memory.
REQ-005 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-006 done  output  1  one-cycle pulse; last lane accepted downstream.
REQ-007 mrx  output  3  state memory read x address, 0..4.
REQ-008 mry  output  3  state memory read y address, 0..4.
REQ-009 mrd  input  64  state memory read data; valid one cycle after address (registered read).
REQ-010 pushout  output  1  dout/firstout valid.
REQ-011 stopout  input  1  downstream not ready.
REQ-012 firstout  output  1  high with lane (0,0) only.
REQ-013 dout  output  64  lane data.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when 25th read issued; DRAIN->IDLE when 25th lane accepted.
REQ-015 start outside IDLE ignored; no restart, no counter disturbance.
REQ-016 Lane order: x fastest, then y: (0,0),(1,0)..(4,0),(0,1)..(4,4); index = 5*y + x.
REQ-017 Read issue: in RUN, one read per cycle when buffer occupancy + reads in flight < FIFO_DEPTH; non-issuing cycles hold mrx/mry unchanged.
REQ-018 Read data captured into buffer the cycle after issue, tagged first=1 for lane 0.
REQ-019 Transfer occurs when pushout && !stopout at rising edge; buffer head pops on transfer.
REQ-020 pushout high whenever buffer non-empty; dout/firstout = head entry, registered, glitch-free.
REQ-021 While pushout && stopout, pushout, dout, firstout held stable.
REQ-022 Latency: start sampled at edge T -> first read address in cycle T+1 -> pushout=1 with lane 0 in cycle T+3.
REQ-023 stopout held low: 25 lanes on 25 consecutive cycles, no bubbles.
REQ-024 Buffer never overflows; simultaneous capture and pop at full occupancy preserves order.
REQ-025 done pulses the cycle after the 25th transfer; busy falls with done; FSM in IDLE same cycle.
REQ-026 start in done cycle is ignored; start the following cycle accepted.
REQ-027 Lane counter 5 bits, saturates at 25, never wraps; x/y counters wrap 4->0 with carry into y.

Reset
REQ-028 On rst: FSM IDLE; busy, done, pushout, firstout = 0; dout = 0; mrx, mry = 0; buffer empty; counters 0.
REQ-029 rst mid-stream aborts immediately; no further pushout until next start; in-flight read data discarded.
REQ-030 Reset deassertion synchronous to clk; first accepted start no earlier than cycle after deassert.

Structure
REQ-031 Shared package perm_pkg holds LANES, lane-index-to-(x,y) constants, FSM state enum shared with perm_blk.
REQ-032 One sub-module lane_fifo: FIFO_DEPTH-entry, 65-bit (data+first tag) synchronous FIFO, count output.
REQ-033 Top holds FSM, address counters, credit logic; no combinational path stopout->mrx/mry.

Verification
REQ-034 Memory lane(x,y)=64'h0101_0101_0000_0000 + 5*y + x; start, stopout=0 -> 25 lanes in order on cycles T+3..T+27, firstout only on first, done at T+28.
REQ-035 stopout toggling 1/0 each cycle -> same 25 values in order, none duplicated or dropped, done after 25th transfer.
REQ-036 stopout held high 10 cycles while lane 7 presented -> dout stays lane 7 value, pushout=1 throughout, no reads issued once buffer full, resumes at lane 7.
REQ-037 start pulsed at lane 12 while busy -> ignored; exactly 25 lanes, one done.
REQ-038 rst asserted at lane 12 -> pushout=0, busy=0 next edge; new start -> full 25-lane stream from lane 0 with firstout.
REQ-039 start on cycle after done -> second full stream, first lane at start+3, no stale data.
